// File: rtl/bcd_up_counter_pkg.sv
// Shared constants and the BCD digit type for the decimal counter.
package bcd_up_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_up_counter_digit.sv
// One decimal digit: a 0..9 register with a sanitising synchronous load.
module bcd_digit
  import bcd_up_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       inc,
  output bcd_digit_t q,
  output logic       is_nine,
  output logic       bad_load
);

  bcd_digit_t r_q;

  assign bad_load = (load_d > BCD_MAX);
  assign is_nine  = (r_q == BCD_MAX);
  assign q        = r_q;

  // Out-of-range load digits are stored as 0 so the register never leaves 0..9.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= bad_load ? bcd_digit_t'(0) : load_d;
    end else if (inc) begin
      r_q <= is_nine ? bcd_digit_t'(0) : r_q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_up_counter.sv
// Multi-digit synchronous BCD up counter with load, cascade terminal count,
// sticky overflow and a one-cycle bad-load pulse.
module bcd_up_counter
  import bcd_up_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  logic [DIGITS-1:0] w_inc;
  logic [DIGITS-1:0] w_is_nine;
  logic [DIGITS-1:0] w_bad_load;
  logic              w_all_nine;
  logic              r_ovf;
  logic              r_load_err;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    // Ripple carry: a digit advances only when every lower digit is 9.
    if (gi == 0) begin : g_lsd
      assign w_inc[gi] = en & ~load;
    end else begin : g_upper
      assign w_inc[gi] = w_inc[gi-1] & w_is_nine[gi-1];
    end

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_d   (load_val[4*gi +: 4]),
      .inc      (w_inc[gi]),
      .q        (count[4*gi +: 4]),
      .is_nine  (w_is_nine[gi]),
      .bad_load (w_bad_load[gi])
    );
  end

  assign w_all_nine = &w_is_nine;
  assign tc         = w_all_nine & en & ~load;
  assign ovf        = r_ovf;
  assign load_err   = r_load_err;

  // tc high means this edge wraps all-9s to all-0s.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= load & (|w_bad_load);
      if (load) begin
        r_ovf <= 1'b0;
      end else if (tc) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_up_counter.sv
// Directed bench for bcd_up_counter: a 4-digit instance plus a two-stage
// cascade of 1-digit instances chained through tc.
module tb_bcd_up_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc;
  logic        ovf;
  logic        load_err;

  logic        c_rst;
  logic        c_en;
  logic [3:0]  lo_count;
  logic [3:0]  hi_count;
  logic        lo_tc;
  logic        hi_tc;
  logic        lo_ovf;
  logic        hi_ovf;
  logic        lo_load_err;
  logic        hi_load_err;

  int n_cmp;
  int n_bad;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_up_counter #(.DIGITS(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .load_err (load_err)
  );

  bcd_up_counter #(.DIGITS(1)) u_lo (
    .clk      (clk),
    .rst      (c_rst),
    .en       (c_en),
    .load     (1'b0),
    .load_val (4'd0),
    .count    (lo_count),
    .tc       (lo_tc),
    .ovf      (lo_ovf),
    .load_err (lo_load_err)
  );

  bcd_up_counter #(.DIGITS(1)) u_hi (
    .clk      (clk),
    .rst      (c_rst),
    .en       (lo_tc),
    .load     (1'b0),
    .load_val (4'd0),
    .count    (hi_count),
    .tc       (hi_tc),
    .ovf      (hi_ovf),
    .load_err (hi_load_err)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    en       = 1'b1;
    load     = 1'b1;
    load_val = 16'h1234;
    c_rst    = 1'b1;
    c_en     = 1'b0;

    // reset dominates load and en
    step();
    step();
    check("rst_count", count, 32'h0000);
    check("rst_ovf", ovf, 0);
    check("rst_load_err", load_err, 0);
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b1;
    step();
    check("first_inc", count, 32'h0001);

    // carry across two digits
    load = 1'b1; en = 1'b0; load_val = 16'h0099;
    step();
    check("load_0099", count, 32'h0099);
    check("load_0099_err", load_err, 0);
    load = 1'b0; en = 1'b1;
    settle();
    check("tc_0099", tc, 0);
    step();
    check("carry_0100", count, 32'h0100);
    check("tc_0100", tc, 0);

    // wrap, tc timing and sticky ovf
    load = 1'b1; en = 1'b0; load_val = 16'h9998;
    step();
    load = 1'b0; en = 1'b1;
    settle();
    check("tc_9998", tc, 0);
    step();
    check("count_9999", count, 32'h9999);
    check("tc_9999", tc, 1);
    check("ovf_pre_wrap", ovf, 0);
    en = 1'b0;
    settle();
    check("tc_9999_en0", tc, 0);
    en = 1'b1; load = 1'b1;
    settle();
    check("tc_9999_load", tc, 0);
    load = 1'b0;
    step();
    check("wrap_count", count, 32'h0000);
    check("wrap_ovf", ovf, 1);
    check("tc_after_wrap", tc, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("ovf_sticky", ovf, 1);
      check("count_after_wrap", count, 32'(i));
    end
    en = 1'b0;
    step();
    check("ovf_hold", ovf, 1);
    check("count_hold_ovf", count, 32'h0005);
    load = 1'b1; load_val = 16'h0010;
    step();
    check("ovf_clr_load", ovf, 0);
    check("count_0010", count, 32'h0010);

    // sanitising load
    load_val = 16'h3A7F;
    step();
    check("bad_load_count", count, 32'h3070);
    check("bad_load_err", load_err, 1);
    load = 1'b0;
    step();
    check("bad_load_err_drop", load_err, 0);
    check("bad_load_hold", count, 32'h3070);

    // priority: rst > load > en > hold
    rst = 1'b1; load = 1'b1; en = 1'b1; load_val = 16'h5555;
    step();
    check("prio_rst", count, 32'h0000);
    check("prio_rst_err", load_err, 0);
    rst = 1'b0; load_val = 16'h0042;
    step();
    check("prio_load", count, 32'h0042);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_0042", count, 32'h0042);
    end

    // cascade of two 1-digit counters
    step();
    c_rst = 1'b0; c_en = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("casc_lo_9", lo_count, 9);
    check("casc_hi_0", hi_count, 0);
    check("casc_lo_tc", lo_tc, 1);
    for (int i = 0; i < 16; i++) step();
    check("casc_lo_5", lo_count, 5);
    check("casc_hi_2", hi_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
